tpu_seq_ctrl: RTL and testbench

// - Sequencer behind the MMIO status/control bits.
// - On a start pulse it latches the M/N/K dimensions and walks the (row, col, k) loop nest.
// - It issues one MAC operation per accepted beat to the systolic datapath over a valid/ready handshake.
// - It then waits a fixed drain latency and reports done.
// - It drives tpu_idle/tpu_working/tpu_done and a working-cycle counter back to the register file.

---
 rtl/tpu_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tpu_seq_ctrl : walks the (row, col, k) MAC loop nest for one matmul job,
//                drains the datapath, and reports idle/working/done status.
// Revision 1.0
// ============================================================================
module tpu_seq_ctrl #(
   parameter int DIM_W     = 6,
   parameter int DRAIN_CYC = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIM_W-1:0] dim_m,
   input  logic [DIM_W-1:0] dim_n,
   input  logic [DIM_W-1:0] dim_k,
   output logic             idle,
   output logic             working,
   output logic             done,
   output logic             err_dim,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [DIM_W-1:0] op_row,
   output logic [DIM_W-1:0] op_col,
   output logic [DIM_W-1:0] op_k,
   output logic             op_first,
   output logic             op_last,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYC);
   localparam logic [DRN_W-1:0] DRAIN_ONE  = DRN_W'(1);
   localparam logic [DIM_W-1:0] DIM_ONE    = DIM_W'(1);
   localparam logic [DIM_W-1:0] DIM_ZERO   = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [DIM_W-1:0] m_q, n_q, k_q;
   logic [DIM_W-1:0] row, col, kk;
   logic [DRN_W-1:0] drain;
   logic             err_q;
   logic [CNT_W-1:0] cnt;

   logic row_end, col_end, k_end, last_elem, zero_dim;

   assign row_end   = (row == m_q - DIM_ONE);
   assign col_end   = (col == n_q - DIM_ONE);
   assign k_end     = (kk  == k_q - DIM_ONE);
   assign last_elem = row_end && col_end && k_end;
   assign zero_dim  = (dim_m == DIM_ZERO) || (dim_n == DIM_ZERO) || (dim_k == DIM_ZERO);

   // Status flags decode straight from the state register so reset clears them asynchronously.
   assign idle      = (state == S_IDLE) || (state == S_DONE);
   assign working   = (state == S_ISSUE) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign op_valid  = (state == S_ISSUE);
   assign err_dim   = err_q;
   assign op_row    = row;
   assign op_col    = col;
   assign op_k      = kk;
   assign op_first  = op_valid && (kk == DIM_ZERO);
   assign op_last   = op_valid && k_end;
   assign cycle_cnt = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         m_q   <= '0;
         n_q   <= '0;
         k_q   <= '0;
         row   <= '0;
         col   <= '0;
         kk    <= '0;
         drain <= '0;
         err_q <= 1'b0;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  m_q   <= dim_m;
                  n_q   <= dim_n;
                  k_q   <= dim_k;
                  row   <= '0;
                  col   <= '0;
                  kk    <= '0;
                  cnt   <= '0;
                  err_q <= zero_dim;
                  state <= zero_dim ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt <= (&cnt) ? cnt : cnt + 1'b1;
               if (op_ready) begin
                  // k innermost, row outermost; indices return to zero after the final beat.
                  if (k_end) begin
                     kk <= '0;
                     if (col_end) begin
                        col <= '0;
                        row <= row_end ? DIM_ZERO : row + DIM_ONE;
                     end else begin
                        col <= col + DIM_ONE;
                     end
                  end else begin
                     kk <= kk + DIM_ONE;
                  end
                  if (last_elem) begin
                     drain <= DRAIN_INIT;
                     state <= (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               cnt   <= (&cnt) ? cnt : cnt + 1'b1;
               drain <= drain - DRAIN_ONE;
               if (drain == DRAIN_ONE) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tpu_seq_ctrl : table of jobs with random op_ready, checked against a
//                   loop-nest model of the expected MAC beat stream.
// Revision 1.0
// ============================================================================
module tb_tpu_seq_ctrl;

   localparam int DIM_W     = 6;
   localparam int DRAIN_CYC = 4;
   localparam int CNT_W     = 16;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [DIM_W-1:0] dim_m = '0, dim_n = '0, dim_k = '0;
   logic             idle, working, done, err_dim, op_valid, op_first, op_last;
   logic             op_ready = 1'b0;
   logic [DIM_W-1:0] op_row, op_col, op_k;
   logic [CNT_W-1:0] cycle_cnt;

   int checks = 0;
   int failures = 0;

   tpu_seq_ctrl #(.DIM_W(DIM_W), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
      .idle(idle), .working(working), .done(done), .err_dim(err_dim),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_row(op_row), .op_col(op_col), .op_k(op_k),
      .op_first(op_first), .op_last(op_last), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m, n, k;
      int ready_pct;
      bit inject;
      int exp_beats;
      bit exp_err;
   } job_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: the expected beat stream is the plain nested loop row{col{k}}.
   task automatic run_job(input job_t j);
      int qr[$], qc[$], qk[$];
      bit zero;
      int issue_cyc, beats, guard;
      int exp_cnt;
      zero = (j.m == 0) || (j.n == 0) || (j.k == 0);
      for (int r = 0; r < j.m; r++)
         for (int c = 0; c < j.n; c++)
            for (int x = 0; x < j.k; x++) begin
               qr.push_back(r); qc.push_back(c); qk.push_back(x);
            end
      chk("idle_before_start", {31'd0, idle}, 1);
      start = 1'b1;
      dim_m = DIM_W'(j.m); dim_n = DIM_W'(j.n); dim_k = DIM_W'(j.k);
      tick();
      start = 1'b0;
      dim_m = DIM_W'($urandom_range(1, 63));
      dim_n = DIM_W'($urandom_range(1, 63));
      dim_k = DIM_W'($urandom_range(1, 63));
      issue_cyc = 0;
      beats = 0;
      guard = 0;
      while (qr.size() > 0 && guard < 80000) begin
         chk("issue_valid", {31'd0, op_valid}, 1);
         chk("issue_working", {31'd0, working}, 1);
         chk("issue_not_done", {31'd0, done}, 0);
         chk("op_row", {26'd0, op_row}, qr[0]);
         chk("op_col", {26'd0, op_col}, qc[0]);
         chk("op_k", {26'd0, op_k}, qk[0]);
         chk("op_first", {31'd0, op_first}, (qk[0] == 0) ? 1 : 0);
         chk("op_last", {31'd0, op_last}, (qk[0] == j.k - 1) ? 1 : 0);
         if (j.inject && issue_cyc == 3) begin
            start = 1'b1;
            dim_m = 6'd1; dim_n = 6'd1; dim_k = 6'd1;
         end else begin
            start = 1'b0;
         end
         op_ready = ($urandom_range(99) < j.ready_pct);
         if (op_ready) begin
            void'(qr.pop_front()); void'(qc.pop_front()); void'(qk.pop_front());
            beats++;
         end
         issue_cyc++;
         guard++;
         tick();
      end
      if (guard >= 80000) chk("issue_timeout", 1, 0);
      start = 1'b0;
      op_ready = 1'b0;
      chk("beat_count", beats, j.exp_beats);
      if (!zero) begin
         for (int d = 0; d < DRAIN_CYC; d++) begin
            chk("drain_working", {31'd0, working}, 1);
            chk("drain_no_valid", {31'd0, op_valid}, 0);
            chk("drain_not_done", {31'd0, done}, 0);
            tick();
         end
      end
      exp_cnt = zero ? 0 : issue_cyc + DRAIN_CYC;
      if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
      chk("done", {31'd0, done}, 1);
      chk("done_idle", {31'd0, idle}, 1);
      chk("done_not_working", {31'd0, working}, 0);
      chk("done_no_valid", {31'd0, op_valid}, 0);
      chk("err_dim", {31'd0, err_dim}, {31'd0, j.exp_err});
      chk("cycle_cnt", {16'd0, cycle_cnt}, exp_cnt);
      tick();
      chk("done_held", {31'd0, done}, 1);
      chk("cnt_held", {16'd0, cycle_cnt}, exp_cnt);
   endtask

   job_t jobs[8];

   initial begin
      jobs[0] = '{m: 1,  n: 1,  k: 1,  ready_pct: 100, inject: 0, exp_beats: 1,     exp_err: 0};
      jobs[1] = '{m: 2,  n: 3,  k: 4,  ready_pct: 50,  inject: 0, exp_beats: 24,    exp_err: 0};
      jobs[2] = '{m: 3,  n: 2,  k: 0,  ready_pct: 100, inject: 0, exp_beats: 0,     exp_err: 1};
      jobs[3] = '{m: 2,  n: 2,  k: 3,  ready_pct: 70,  inject: 0, exp_beats: 12,    exp_err: 0};
      jobs[4] = '{m: 2,  n: 3,  k: 4,  ready_pct: 100, inject: 1, exp_beats: 24,    exp_err: 0};
      jobs[5] = '{m: 0,  n: 5,  k: 5,  ready_pct: 100, inject: 0, exp_beats: 0,     exp_err: 1};
      jobs[6] = '{m: 63, n: 1,  k: 2,  ready_pct: 30,  inject: 0, exp_beats: 126,   exp_err: 0};
      jobs[7] = '{m: 40, n: 41, k: 40, ready_pct: 100, inject: 0, exp_beats: 65600, exp_err: 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle", {31'd0, idle}, 1);
      chk("rst_working", {31'd0, working}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, err_dim}, 0);
      chk("rst_valid", {31'd0, op_valid}, 0);
      chk("rst_first", {31'd0, op_first}, 0);
      chk("rst_last", {31'd0, op_last}, 0);
      chk("rst_idx", {8'd0, op_row, op_col, op_k}, 0);
      chk("rst_cnt", {16'd0, cycle_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) run_job(jobs[i]);

      // Reset in the middle of ISSUE while beat 5 is presented.
      op_ready = 1'b1;
      start = 1'b1;
      dim_m = 6'd2; dim_n = 6'd3; dim_k = 6'd4;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("beat5_col", {26'd0, op_col}, 1);
      chk("beat5_k", {26'd0, op_k}, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_idle", {31'd0, idle}, 1);
      chk("mid_rst_valid", {31'd0, op_valid}, 0);
      chk("mid_rst_idx", {8'd0, op_row, op_col, op_k}, 0);
      chk("mid_rst_cnt", {16'd0, cycle_cnt}, 0);
      op_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_job(jobs[1]);

      run_job(jobs[7]);
      run_job(jobs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
